ddr_init_sequencer: RTL and testbench

DDR_INIT_SEQUENCER -- requirements
Module: ddr_init_sequencer

---
 rtl/ddr_init_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_ddr_init_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_sequencer.sv
// DDR3 power-up sequencer: reset/CKE timing, MR2/MR3/MR1/MR0 loads, ZQCL, calibration handshake.
// Outputs registered one cycle behind the state; no backpressure, waits are counter-timed except CALI_WAIT.
module ddr_init_sequencer #(
  parameter int T_RESET      = 200,
  parameter int T_CKE        = 500,
  parameter int T_XPR        = 120,
  parameter int T_MRD        = 4,
  parameter int T_MOD        = 12,
  parameter int T_ZQINIT     = 512,
  parameter int CALI_TIMEOUT = 65535
) (
  input  logic        core_clk,
  input  logic        core_arstn,
  input  logic        init_start,
  input  logic [13:0] mr0,
  input  logic [13:0] mr1,
  input  logic [13:0] mr2,
  input  logic [13:0] mr3,
  input  logic        cali_done,
  output logic        cali_start,
  output logic        dfi_reset_n,
  output logic        dfi_cke,
  output logic        dfi_cs_n,
  output logic        dfi_ras_n,
  output logic        dfi_cas_n,
  output logic        dfi_we_n,
  output logic [2:0]  dfi_bank,
  output logic [13:0] dfi_address,
  output logic        init_done,
  output logic        init_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_HOLD, S_CKE_WAIT, S_XPR_WAIT, S_MRS, S_MRS_WAIT,
    S_ZQCL, S_ZQ_WAIT, S_CALI, S_CALI_WAIT, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] LD_RESET  = 16'(T_RESET - 1);
  localparam logic [15:0] LD_CKE    = 16'(T_CKE - 1);
  localparam logic [15:0] LD_XPR    = 16'(T_XPR - 1);
  localparam logic [15:0] LD_MRD    = 16'(T_MRD - 1);
  localparam logic [15:0] LD_MOD    = 16'(T_MOD - 1);
  localparam logic [15:0] LD_ZQINIT = 16'(T_ZQINIT - 1);
  localparam logic [15:0] LD_CALI   = 16'(CALI_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  seq_q, seq_d;
  logic [1:0]  mr_num;
  logic [13:0] mr_sel;
  logic        cnt_zero;

  logic        dfi_reset_n_q, dfi_reset_n_d;
  logic        dfi_cke_q, dfi_cke_d;
  logic        dfi_cs_n_q, dfi_cs_n_d;
  logic        dfi_ras_n_q, dfi_ras_n_d;
  logic        dfi_cas_n_q, dfi_cas_n_d;
  logic        dfi_we_n_q, dfi_we_n_d;
  logic [2:0]  dfi_bank_q, dfi_bank_d;
  logic [13:0] dfi_address_q, dfi_address_d;
  logic        cali_start_q, cali_start_d;
  logic        init_done_q, init_done_d;
  logic        init_error_q, init_error_d;

  assign cnt_zero = (cnt_q == 16'd0);

  // seq_q is the load position; JEDEC order loads MR2, MR3, MR1, then MR0
  always_comb begin
    mr_num = 2'd2;
    mr_sel = mr2;
    case (seq_q)
      2'd0: begin mr_num = 2'd2; mr_sel = mr2; end
      2'd1: begin mr_num = 2'd3; mr_sel = mr3; end
      2'd2: begin mr_num = 2'd1; mr_sel = mr1; end
      2'd3: begin mr_num = 2'd0; mr_sel = mr0; end
      default: ;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      seq_q         <= '0;
      dfi_reset_n_q <= 1'b0;
      dfi_cke_q     <= 1'b0;
      dfi_cs_n_q    <= 1'b1;
      dfi_ras_n_q   <= 1'b1;
      dfi_cas_n_q   <= 1'b1;
      dfi_we_n_q    <= 1'b1;
      dfi_bank_q    <= '0;
      dfi_address_q <= '0;
      cali_start_q  <= 1'b0;
      init_done_q   <= 1'b0;
      init_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seq_q         <= seq_d;
      dfi_reset_n_q <= dfi_reset_n_d;
      dfi_cke_q     <= dfi_cke_d;
      dfi_cs_n_q    <= dfi_cs_n_d;
      dfi_ras_n_q   <= dfi_ras_n_d;
      dfi_cas_n_q   <= dfi_cas_n_d;
      dfi_we_n_q    <= dfi_we_n_d;
      dfi_bank_q    <= dfi_bank_d;
      dfi_address_q <= dfi_address_d;
      cali_start_q  <= cali_start_d;
      init_done_q   <= init_done_d;
      init_error_q  <= init_error_d;
    end
  end

  // Wait states load their count on entry and leave when it reads zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_RST_HOLD;
          cnt_d   = LD_RESET;
          seq_d   = 2'd0;
        end
      end
      S_RST_HOLD: begin
        if (cnt_zero) begin
          state_d = S_CKE_WAIT;
          cnt_d   = LD_CKE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CKE_WAIT: begin
        if (cnt_zero) begin
          state_d = S_XPR_WAIT;
          cnt_d   = LD_XPR;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_XPR_WAIT: begin
        if (cnt_zero) state_d = S_MRS;
        else          cnt_d   = cnt_q - 16'd1;
      end
      S_MRS: begin
        state_d = S_MRS_WAIT;
        cnt_d   = (seq_q == 2'd3) ? LD_MOD : LD_MRD;
      end
      S_MRS_WAIT: begin
        if (cnt_zero) begin
          if (seq_q == 2'd3) begin
            state_d = S_ZQCL;
            seq_d   = 2'd0;
          end else begin
            state_d = S_MRS;
            seq_d   = seq_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_ZQCL: begin
        state_d = S_ZQ_WAIT;
        cnt_d   = LD_ZQINIT;
      end
      S_ZQ_WAIT: begin
        if (cnt_zero) state_d = S_CALI;
        else          cnt_d   = cnt_q - 16'd1;
      end
      S_CALI: begin
        state_d = S_CALI_WAIT;
        cnt_d   = LD_CALI;
      end
      // cali_done wins over an expiring timeout in the same cycle
      S_CALI_WAIT: begin
        if (cali_done)     state_d = S_DONE;
        else if (cnt_zero) state_d = S_ERROR;
        else               cnt_d   = cnt_q - 16'd1;
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dfi_reset_n_d = 1'b1;
    dfi_cke_d     = 1'b1;
    dfi_cs_n_d    = 1'b0;
    dfi_ras_n_d   = 1'b1;
    dfi_cas_n_d   = 1'b1;
    dfi_we_n_d    = 1'b1;
    dfi_bank_d    = '0;
    dfi_address_d = '0;
    cali_start_d  = 1'b0;
    init_done_d   = 1'b0;
    init_error_d  = 1'b0;
    case (state_q)
      S_IDLE, S_RST_HOLD: begin
        dfi_reset_n_d = 1'b0;
        dfi_cke_d     = 1'b0;
        dfi_cs_n_d    = 1'b1;
      end
      S_CKE_WAIT: begin
        dfi_cke_d  = 1'b0;
        dfi_cs_n_d = 1'b1;
      end
      S_MRS: begin
        dfi_ras_n_d   = 1'b0;
        dfi_cas_n_d   = 1'b0;
        dfi_we_n_d    = 1'b0;
        dfi_bank_d    = {1'b0, mr_num};
        dfi_address_d = mr_sel;
      end
      S_ZQCL: begin
        dfi_we_n_d    = 1'b0;
        dfi_address_d = 14'h0400;
      end
      S_CALI:  cali_start_d = 1'b1;
      S_DONE:  init_done_d  = 1'b1;
      S_ERROR: init_error_d = 1'b1;
      default: ;
    endcase
  end

  assign dfi_reset_n = dfi_reset_n_q;
  assign dfi_cke     = dfi_cke_q;
  assign dfi_cs_n    = dfi_cs_n_q;
  assign dfi_ras_n   = dfi_ras_n_q;
  assign dfi_cas_n   = dfi_cas_n_q;
  assign dfi_we_n    = dfi_we_n_q;
  assign dfi_bank    = dfi_bank_q;
  assign dfi_address = dfi_address_q;
  assign cali_start  = cali_start_q;
  assign init_done   = init_done_q;
  assign init_error  = init_error_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Bench for ddr_init_sequencer: per-edge expected outputs queued with the stimulus, popped after each edge.
// Edge 0 is the edge that samples init_start in IDLE; all timings use the short bench parameters.
module tb_ddr_init_sequencer;

  localparam int T_RESET      = 4;
  localparam int T_CKE        = 5;
  localparam int T_XPR        = 3;
  localparam int T_MRD        = 4;
  localparam int T_MOD        = 12;
  localparam int T_ZQINIT     = 8;
  localparam int CALI_TIMEOUT = 20;
  localparam int NEVER        = 1 << 30;

  localparam logic [13:0] MR0 = 14'h1D70;
  localparam logic [13:0] MR1 = 14'h0044;
  localparam logic [13:0] MR2 = 14'h0018;
  localparam logic [13:0] MR3 = 14'h0000;

  typedef struct packed {
    logic        reset_n;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [2:0]  bank;
    logic [13:0] addr;
    logic        cali_start;
    logic        done;
    logic        error;
  } out_t;

  logic        core_clk = 1'b0;
  logic        core_arstn = 1'b0;
  logic        init_start = 1'b0;
  logic        cali_done = 1'b0;
  logic [13:0] mr0 = MR0;
  logic [13:0] mr1 = MR1;
  logic [13:0] mr2 = MR2;
  logic [13:0] mr3 = MR3;
  logic        cali_start;
  logic        dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [2:0]  dfi_bank;
  logic [13:0] dfi_address;
  logic        init_done, init_error;

  out_t act;
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 core_clk = ~core_clk;

  ddr_init_sequencer #(
    .T_RESET(T_RESET), .T_CKE(T_CKE), .T_XPR(T_XPR), .T_MRD(T_MRD),
    .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT), .CALI_TIMEOUT(CALI_TIMEOUT)
  ) dut (
    .core_clk(core_clk), .core_arstn(core_arstn), .init_start(init_start),
    .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3),
    .cali_done(cali_done), .cali_start(cali_start),
    .dfi_reset_n(dfi_reset_n), .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n),
    .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_bank(dfi_bank), .dfi_address(dfi_address),
    .init_done(init_done), .init_error(init_error)
  );

  assign act = {dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
                dfi_bank, dfi_address, cali_start, init_done, init_error};

  // Expected outputs right after edge e; fin_e is the first edge showing done/error
  function automatic out_t exp_vec(input int e, input int fin_e, input bit fin_err);
    out_t v;
    v = '0;
    v.cs_n  = 1'b1;
    v.ras_n = 1'b1;
    v.cas_n = 1'b1;
    v.we_n  = 1'b1;
    if (e >= 5) v.reset_n = 1'b1;
    if (e >= 10) begin
      v.cke  = 1'b1;
      v.cs_n = 1'b0;
    end
    case (e)
      13: begin {v.ras_n, v.cas_n, v.we_n} = 3'b000; v.bank = 3'd2; v.addr = MR2; end
      18: begin {v.ras_n, v.cas_n, v.we_n} = 3'b000; v.bank = 3'd3; v.addr = MR3; end
      23: begin {v.ras_n, v.cas_n, v.we_n} = 3'b000; v.bank = 3'd1; v.addr = MR1; end
      28: begin {v.ras_n, v.cas_n, v.we_n} = 3'b000; v.bank = 3'd0; v.addr = MR0; end
      41: begin v.we_n = 1'b0; v.addr = 14'h0400; end
      50: v.cali_start = 1'b1;
      default: ;
    endcase
    if (e >= fin_e) begin
      if (fin_err) v.error = 1'b1;
      else         v.done  = 1'b1;
    end
    return v;
  endfunction

  task automatic step(input bit start, input bit cdone, input bit rstn, input out_t exp);
    init_start = start;
    cali_done  = cdone;
    core_arstn = rstn;
    exp_q.push_back(exp);
    @(posedge core_clk);
    #1;
  endtask

  task automatic do_reset();
    init_start = 1'b0;
    cali_done  = 1'b0;
    core_arstn = 1'b0;
    repeat (2) @(posedge core_clk);
    #1;
    core_arstn = 1'b1;
  endtask

  task automatic test_reset();
    out_t want;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, (i >= 2), exp_vec(0, NEVER, 1'b0));
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, act, want);
      end
    end
  endtask

  // init_start held high throughout; cali_done pulses in XPR_WAIT and in the CALI cycle
  task automatic test_full_sequence();
    out_t want;
    do_reset();
    for (int e = 0; e < 80; e++) begin
      step(1'b1, ((e >= 10 && e <= 12) || e == 50 || e >= 53), 1'b1, exp_vec(e, 54, 1'b0));
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL full_seq edge %0d: got %h expected %h", e, act, want);
      end
    end
  endtask

  task automatic test_timeout();
    out_t want;
    do_reset();
    for (int e = 0; e < 76; e++) begin
      step((e == 0), 1'b0, 1'b1, exp_vec(e, 71, 1'b1));
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL timeout edge %0d: got %h expected %h", e, act, want);
      end
    end
  endtask

  task automatic test_done_on_last_cycle();
    out_t want;
    do_reset();
    for (int e = 0; e < 76; e++) begin
      step((e == 0), (e == 70), 1'b1, exp_vec(e, 71, 1'b0));
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL last_cycle_done edge %0d: got %h expected %h", e, act, want);
      end
    end
  endtask

  // Reset lands in MRS_WAIT after MR1, then the whole sequence replays from MR2
  task automatic test_reset_mid_sequence();
    out_t want;
    do_reset();
    for (int e = 0; e < 28; e++) begin
      if (e < 25)
        step((e == 0), 1'b0, 1'b1, exp_vec(e, NEVER, 1'b0));
      else
        step(1'b0, 1'b0, (e != 25), exp_vec(0, NEVER, 1'b0));
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL mid_reset edge %0d: got %h expected %h", e, act, want);
      end
    end
    for (int e = 0; e < 60; e++) begin
      step((e == 0), (e >= 53), 1'b1, exp_vec(e, 54, 1'b0));
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL replay edge %0d: got %h expected %h", e, act, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_timeout();
    test_done_on_last_cycle();
    test_reset_mid_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
